vga_line_fetch: RTL

//  Pixel source for the VGA timing stage. Prefetches one image line from SPRAM into a

---
 rtl/vga_fetch_pkg.sv | 16 +
 rtl/line_buf_dp.sv | 23 ++
 rtl/vga_line_fetch.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/vga_fetch_pkg.sv
// Shared constants and FSM encoding for the VGA line-fetch path.
// The default geometry is also used by the VGA timing block.
package vga_fetch_pkg;

   localparam logic [7:0] ST_DISPLAY   = 8'h03;
   localparam int         H_ACTIVE_DEF = 640;
   localparam int         V_ACTIVE_DEF = 480;
   localparam int         PIX_W_DEF    = 16;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DRAIN
   } fetch_state_e;

endpackage

// File: rtl/line_buf_dp.sv
// Simple dual-port line buffer: one write port and a registered read port.
// The MSB of each address selects the ping-pong bank.
module line_buf_dp #(
   parameter int AW = 4,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   // NOTE: storage has no reset, so it maps onto block RAM; readers gate stale contents.
   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/vga_line_fetch.sv
// Prefetches the next image line from SPRAM into a ping-pong buffer while the
// current line is displayed, then streams pixels to the VGA pins.
module vga_line_fetch
   import vga_fetch_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int ADDR_W   = 18,
   parameter int PIX_W    = PIX_W_DEF,
   parameter int IMG_BASE = 0
) (
   input  logic              i_clk_sys,
   input  logic              i_rst,
   input  logic [7:0]        i_state,
   input  logic              i_rd_sig,
   input  logic [11:0]       i_xpos,
   input  logic [11:0]       i_ypos,
   input  logic              i_vga_vs,
   output logic              o_sram_req,
   output logic [ADDR_W-1:0] o_sram_addr,
   input  logic              i_sram_ack,
   input  logic [PIX_W-1:0]  i_sram_rdata,
   output logic [PIX_W-1:0]  o_rgb,
   output logic              o_fetch_busy,
   output logic              o_underrun
);

   localparam int                XW     = $clog2(H_ACTIVE);
   localparam logic [XW-1:0]     X_LAST = XW'(H_ACTIVE - 1);
   localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(IMG_BASE);
   localparam logic [ADDR_W-1:0] LINE   = ADDR_W'(H_ACTIVE);

   fetch_state_e      state, state_n;
   logic [XW-1:0]     x, x_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic [ADDR_W-1:0] pend_addr, pend_addr_n;
   logic              wr_bank, wr_bank_n;
   logic              pend_bank, pend_bank_n;
   logic [ADDR_W-1:0] next_base;
   logic              rd_bank, vs_q, rd_q, underrun, rd_ok, we;
   logic [PIX_W-1:0]  buf_q;

   logic              display, frame_start, line_start, line_end, line_fetch, start_fetch;
   logic [ADDR_W-1:0] start_addr;
   logic              start_bank;

   assign display     = (i_state == ST_DISPLAY);
   assign frame_start = vs_q && !i_vga_vs && display;
   assign line_start  = !rd_q && i_rd_sig;
   assign line_end    = rd_q && !i_rd_sig;
   assign line_fetch  = line_start && (i_ypos < 12'(V_ACTIVE - 1));
   assign start_fetch = frame_start || (display && line_fetch);
   assign start_addr  = frame_start ? BASE : next_base;
   assign start_bank  = frame_start ? 1'b0 : ~rd_bank;

   always_ff @(posedge i_clk_sys) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (i_rst) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_n     = state;
      x_n         = x;
      addr_n      = addr;
      wr_bank_n   = wr_bank;
      pend_addr_n = pend_addr;
      pend_bank_n = pend_bank;
      we          = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_fetch) begin
               state_n   = REQ;
               x_n       = '0;
               addr_n    = start_addr;
               wr_bank_n = start_bank;
            end
         end
         REQ: begin
            if (start_fetch) begin
               if (i_sram_ack) begin
                  x_n       = '0;
                  addr_n    = start_addr;
                  wr_bank_n = start_bank;
               end else begin
                  // The outstanding request must still see its ack before restarting.
                  state_n     = DRAIN;
                  pend_addr_n = start_addr;
                  pend_bank_n = start_bank;
               end
            end else if (i_sram_ack) begin
               we = 1'b1;
               if (!display || x == X_LAST) begin
                  state_n = IDLE;
               end else begin
                  x_n    = x + 1'b1;
                  addr_n = addr + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (start_fetch) begin
               pend_addr_n = start_addr;
               pend_bank_n = start_bank;
            end
            if (i_sram_ack) begin
               state_n   = display ? REQ : IDLE;
               x_n       = '0;
               addr_n    = pend_addr_n;
               wr_bank_n = pend_bank_n;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         x         <= '0;
         addr      <= '0;
         wr_bank   <= 1'b0;
         pend_addr <= '0;
         pend_bank <= 1'b0;
         next_base <= BASE;
         rd_bank   <= 1'b0;
         vs_q      <= 1'b1;
         rd_q      <= 1'b0;
         underrun  <= 1'b0;
         rd_ok     <= 1'b0;
      end else begin
         x         <= x_n;
         addr      <= addr_n;
         wr_bank   <= wr_bank_n;
         pend_addr <= pend_addr_n;
         pend_bank <= pend_bank_n;
         vs_q      <= i_vga_vs;
         rd_q      <= i_rd_sig;
         rd_ok     <= i_rd_sig && display && (i_xpos < 12'(H_ACTIVE));
         if (frame_start)   rd_bank <= 1'b0;
         else if (line_end) rd_bank <= ~rd_bank;
         if (frame_start)                                  underrun <= 1'b0;
         else if (line_start && display && state != IDLE) underrun <= 1'b1;
         // Line base advances by H_ACTIVE per line, avoiding a multiplier.
         if (frame_start)     next_base <= BASE + LINE;
         else if (line_fetch) next_base <= next_base + LINE;
      end
   end

   line_buf_dp #(
      .AW(XW + 1),
      .DW(PIX_W)
   ) u_buf (
      .clk  (i_clk_sys),
      .we   (we),
      .waddr({wr_bank, x}),
      .wdata(i_sram_rdata),
      .raddr({rd_bank, i_xpos[XW-1:0]}),
      .rdata(buf_q)
   );

   assign o_sram_req   = (state != IDLE);
   assign o_sram_addr  = addr;
   assign o_fetch_busy = (state != IDLE);
   assign o_underrun   = underrun;
   assign o_rgb        = rd_ok ? buf_q : '0;

endmodule
